// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader:
// FSM encoding, default geometry and the header range check.
package instr_mem_loader_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = INSTR_W / 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_MAX_WORDS  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A header byte is a word count; zero or anything above the RAM size is rejected.
  function automatic logic hdr_ok(input logic [7:0] n, input int max_words);
    return (n != 8'd0) && ({24'd0, n} <= 32'(max_words));
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_to_word_packer.sv
// Collects four stream bytes into one little-endian 32-bit word. The finished
// word is only updated when the fourth byte arrives, so it holds between words.
module instr_mem_loader_byte_to_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_data,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word,
  output logic [1:0]         byte_idx
);

  logic [1:0]         cnt_q;
  logic [23:0]        asm_q;
  logic [INSTR_W-1:0] word_q;

  // Strobes in the cycle whose rising edge accepts the last byte of a word.
  assign word_valid = byte_en && (cnt_q == 2'd3);
  assign word       = word_q;
  assign byte_idx   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      asm_q  <= 24'd0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q <= 2'd0;
    end else if (byte_en) begin
      case (cnt_q)
        2'd0: asm_q[7:0]   <= byte_data;
        2'd1: asm_q[15:8]  <= byte_data;
        2'd2: asm_q[23:16] <= byte_data;
        default: word_q    <= {byte_data, asm_q};
      endcase
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a byte stream into the instruction RAM while holding
// the core in reset. Stream format: one count byte N, then N little-endian words.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                MAX_WORDS = DEF_MAX_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_wa,
  output logic [INSTR_W-1:0] mem_wd,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_rst
);

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          words_q;
  logic [ADDR_W-1:0]   mem_wa_q;
  logic                done_q;
  logic                err_q;

  logic                accept;
  logic                sess_start;
  logic                hdr_load;
  logic                wr_step;
  logic                set_done;
  logic                set_err;

  logic                pk_word_valid;
  logic [INSTR_W-1:0]  pk_word;
  logic [1:0]          pk_byte_idx;

  // Handshake: a byte moves on a rising edge with byte_valid && byte_ready.
  // byte_ready depends on the state register only, never on byte_valid.
  assign byte_ready = (state_q == ST_HDR) || (state_q == ST_LOAD);
  assign accept     = byte_valid && byte_ready;

  instr_mem_loader_byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (sess_start),
    .byte_en    (accept && (state_q == ST_LOAD)),
    .byte_data  (byte_data),
    .word_valid (pk_word_valid),
    .word       (pk_word),
    .byte_idx   (pk_byte_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    busy       = 1'b0;
    sess_start = 1'b0;
    hdr_load   = 1'b0;
    wr_step    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_HDR;
          sess_start = 1'b1;
        end
      end
      ST_HDR: begin
        busy = 1'b1;
        if (accept) begin
          if (hdr_ok(byte_data, MAX_WORDS)) begin
            state_d  = ST_LOAD;
            hdr_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            set_err = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (pk_word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        wr_step = 1'b1;
        if (words_q == 8'd1) begin
          state_d  = ST_DONE;
          set_done = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and counter advance on the edge that ends the WRITE cycle, so
  // mem_wa/mem_wd are stable for the whole write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= 8'd0;
      mem_wa_q <= BASE_ADDR;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (sess_start) begin
        mem_wa_q <= BASE_ADDR;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
      end
      if (hdr_load) words_q <= byte_data;
      if (set_err)  err_q   <= 1'b1;
      if (wr_step) begin
        mem_wa_q <= mem_wa_q + ADDR_W'(BYTES_PER_WORD);
        words_q  <= words_q - 8'd1;
      end
      if (set_done) done_q <= 1'b1;
    end
  end

  assign mem_wa  = mem_wa_q;
  assign mem_wd  = pk_word;
  assign done    = done_q;
  assign err     = err_q;
  assign cpu_rst = busy;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: two instances (base 0x00 and 0xFC) run
// the same byte stream; every RAM write is checked against a queue of expected writes.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;

  logic        byte_ready0, mem_we0, busy0, done0, err0, cpu_rst0;
  logic [7:0]  mem_wa0;
  logic [31:0] mem_wd0;
  logic        byte_ready1, mem_we1, busy1, done1, err1, cpu_rst1;
  logic [7:0]  mem_wa1;
  logic [31:0] mem_wd1;

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  logic [31:0] ram0[64];
  int          wr_cnt0 = 0;
  logic [7:0]  addr0, addr1;

  instr_mem_loader dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready0), .mem_we(mem_we0), .mem_wa(mem_wa0), .mem_wd(mem_wd0),
    .busy(busy0), .done(done0), .err(err0), .cpu_rst(cpu_rst0)
  );

  instr_mem_loader #(.BASE_ADDR(8'hFC)) dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready1), .mem_we(mem_we1), .mem_wa(mem_wa1), .mem_wd(mem_wd1),
    .busy(busy1), .done(done1), .err(err1), .cpu_rst(cpu_rst1)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we0 === 1'b1) begin
      wr_cnt0++;
      ram0[mem_wa0[7:2]] = mem_wd0;
      check("we0_cpu_rst", cpu_rst0, 1);
      check("we0_pending", exp_q0.size() > 0, 1);
      if (exp_q0.size() > 0) check("we0_addr_data", {mem_wa0, mem_wd0}, exp_q0.pop_front());
    end
    if (mem_we1 === 1'b1) begin
      check("we1_pending", exp_q1.size() > 0, 1);
      if (exp_q1.size() > 0) check("we1_addr_data", {mem_wa1, mem_wd1}, exp_q1.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!(byte_ready0 && byte_ready1) && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", n < 40, 1);
    tick();
    byte_valid = 1'b0;
  endtask

  // gap_at / start_at: byte index after which to idle 5 cycles / pulse start (-1 = never)
  task automatic send_word(input logic [31:0] w, input int gap_at, input int start_at);
    logic [7:0] wa_before;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k == gap_at) repeat (5) tick();
      if (k == start_at) begin
        wa_before = mem_wa0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ign_busy", busy0, 1);
        check("start_ign_ready", byte_ready0, 1);
        check("start_ign_wa0", mem_wa0, addr0);
        check("start_ign_wa_hold", mem_wa0, wa_before);
      end
    end
    exp_q0.push_back({addr0, w});
    exp_q1.push_back({addr1, w});
    addr0 += 8'd4;
    addr1 += 8'd4;
  endtask

  task automatic begin_session(input logic [7:0] n);
    start = 1'b1;
    tick();
    start = 1'b0;
    addr0 = 8'h00;
    addr1 = 8'hFC;
    check("sess_busy", busy0, 1);
    check("sess_cpu_rst", cpu_rst0, 1);
    check("sess_ready", byte_ready0, 1);
    check("sess_flags", {done0, err0, done1, err1}, 4'b0000);
    check("sess_wa0", mem_wa0, 8'h00);
    check("sess_wa1", mem_wa1, 8'hFC);
    send_byte(n);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done0 || err0) && n < 50) begin
      tick();
      n++;
    end
    check("end_wait", n < 50, 1);
  endtask

  task automatic check_ok_end(input logic [31:0] last_word);
    check("ok_done_err0", {done0, err0}, 2'b10);
    check("ok_done_err1", {done1, err1}, 2'b10);
    check("ok_busy_cpu_rst", {busy0, cpu_rst0, busy1, cpu_rst1}, 4'b0000);
    check("ok_ready", byte_ready0, 0);
    check("ok_queue0", exp_q0.size(), 0);
    check("ok_queue1", exp_q1.size(), 0);
    check("ok_wd_hold", mem_wd0, last_word);
  endtask

  task automatic check_reset();
    check("rst_ready_we", {byte_ready0, mem_we0}, 2'b00);
    check("rst_wa0", mem_wa0, 8'h00);
    check("rst_wa1", mem_wa1, 8'hFC);
    check("rst_wd0", mem_wd0, 32'd0);
    check("rst_flags", {busy0, done0, err0, cpu_rst0}, 4'b0000);
  endtask

  logic [31:0] prog[3];
  int          wr_before;
  logic [31:0] w;

  initial begin
    prog[0] = 32'h0FF00083;
    prog[1] = 32'h00100113;
    prog[2] = 32'h0020F1B3;

    repeat (3) tick();
    rst = 1'b0;
    check_reset();
    tick();
    check("idle_no_start", {busy0, byte_ready0}, 2'b00);

    // basic three-word program
    begin_session(8'h03);
    for (int i = 0; i < 3; i++) send_word(prog[i], -1, -1);
    wait_end();
    check_ok_end(prog[2]);
    for (int i = 0; i < 3; i++) check("prog_ram", ram0[i], prog[i]);

    // same program with a 5-cycle stall inside the second word
    wr_before = wr_cnt0;
    begin_session(8'h03);
    for (int i = 0; i < 3; i++) send_word(prog[i], (i == 1) ? 1 : -1, -1);
    wait_end();
    check_ok_end(prog[2]);
    check("gap_wr_count", wr_cnt0 - wr_before, 3);

    // rejected headers
    wr_before = wr_cnt0;
    begin_session(8'h00);
    wait_end();
    check("hdr0_flags", {done0, err0, done1, err1}, 4'b0101);
    check("hdr0_busy", {busy0, cpu_rst0, byte_ready0}, 3'b000);
    begin_session(8'h41);
    wait_end();
    check("hdr65_flags", {done0, err0}, 2'b01);
    tick();
    check("hdr65_hold", {done0, err0, busy0}, 3'b010);
    check("hdr_no_writes", wr_cnt0 - wr_before, 0);
    begin_session(8'h01);
    send_word(32'h12345678, -1, -1);
    wait_end();
    check_ok_end(32'h12345678);

    // reset in the middle of the second word
    wr_before = wr_cnt0;
    begin_session(8'h02);
    send_word(32'hDEADBEEF, -1, -1);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset();
    check("midrst_wr_count", wr_cnt0 - wr_before, 1);
    check("midrst_queue", exp_q0.size(), 0);
    check("midrst_ram", ram0[0], 32'hDEADBEEF);
    begin_session(8'h01);
    send_word(32'hCAFEF00D, -1, -1);
    wait_end();
    check_ok_end(32'hCAFEF00D);
    check("midrst_restart_ram", ram0[0], 32'hCAFEF00D);

    // start pulsed during LOAD; dut1 wraps 0xFC -> 0x00
    begin_session(8'h02);
    send_word(32'hA5A55A5A, -1, -1);
    send_word(32'h01020304, -1, 1);
    wait_end();
    check_ok_end(32'h01020304);

    // full 64-word load with a counting pattern
    wr_before = wr_cnt0;
    begin_session(8'h40);
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_word(w, -1, -1);
    end
    wait_end();
    check_ok_end({8'd255, 8'd254, 8'd253, 8'd252});
    check("full_wr_count", wr_cnt0 - wr_before, 64);
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      check("full_readback", ram0[i], w);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side counterpart of the instruction memory read port. Receives a program as a byte stream (valid/ready) and writes 32-bit little-endian words into the instruction RAM at consecutive word addresses.
- Holds the core in reset while loading. Sits between the host byte link (e.g. UART RX) and the instruction RAM write port.
- The core keeps reading through the existing 8-bit byte address / 32-bit data port.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory (word-aligned, step 4)
- MAX_WORDS, 64, maximum loadable words (2^ADDR_W / 4)
- BASE_ADDR, 8'h00, byte address of the first written word

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a load session when idle or done
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction RAM write enable, one-cycle pulse per word
- mem_wa  out  ADDR_W  instruction RAM byte address, word-aligned
- mem_wd  out  32  instruction RAM write data
- busy  out  1  session in progress
- done  out  1  last session completed successfully
- err  out  1  last session rejected (bad header)
- cpu_rst  out  1  holds core in reset; equals busy

Behaviour:
- Reset (rst=1 at an edge): state IDLE, byte_ready=0, mem_we=0, mem_wa=BASE_ADDR, mem_wd=0, busy=0, done=0, err=0, cpu_rst=0, byte counter=0, word counter=0. Applies mid-session too: a partial word is discarded and already-written words stay in RAM.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is combinational from state only, never from byte_valid.
- States:
  - IDLE: byte_ready=0. start → HDR; clear done and err; mem_wa=BASE_ADDR.
  - HDR: byte_ready=1. Accepted byte N = word count.
    - N in 1..MAX_WORDS → LOAD, word counter=N.
    - N=0 or N>MAX_WORDS → DONE with err=1, done=0.
  - LOAD: byte_ready=1. Byte k (k=0..3) of a word goes to mem_wd[8k+7:8k] (little-endian). Accepting the 4th byte → WRITE.
  - WRITE: byte_ready=0, mem_we=1 for exactly this cycle with the current mem_wa/mem_wd.
    - Next edge: mem_wa += 4 (mod 2^ADDR_W), word counter −1.
    - Counter reaches 0 → DONE with done=1. Otherwise → LOAD.
  - DONE: byte_ready=0, done or err held. start → HDR; clear flags; mem_wa=BASE_ADDR.
- busy=1 and cpu_rst=1 in HDR, LOAD and WRITE; 0 otherwise.
- start is ignored in HDR, LOAD and WRITE.
- Latency: mem_we is asserted in the cycle after the edge that accepts the 4th byte of a word. Minimum session is 1+4N accepting cycles plus N WRITE cycles.
- Gaps (byte_valid=0) in any accepting state: hold all state, no timeout.
- mem_wd holds its last value outside WRITE. mem_wa wraps modulo 2^ADDR_W when BASE_ADDR≠0.

Decomposition:
- Shared package: state encoding (IDLE, HDR, LOAD, WRITE, DONE), ADDR_W, MAX_WORDS, instruction width 32.
- One natural sub-module, byte_to_word_packer: byte counter plus 32-bit shift/assemble register, with a word_valid strobe. The FSM stays in the top.

Test Plan:
- Reset, then start; header 0x03; bytes 83 00 F0 0F, 13 01 10 00, B3 F1 20 00 → writes 0x0FF00083@0x00, 0x00100113@0x04, 0x0020F1B3@0x08. done=1, err=0, cpu_rst falls after the last write.
- Same stream with byte_valid dropped for 5 cycles mid-word → identical writes, no extra mem_we.
- Header 0x00, then header 0x41 (65) → no mem_we, err=1, done=0, return to DONE. A following start with a valid session clears err.
- rst asserted after 6 data bytes of a 2-word load → one word written at 0x00, all outputs at reset values next cycle. A new session starts again at 0x00.
- start pulsed during LOAD → ignored. BASE_ADDR=8'hFC with 2 words → writes at 0xFC then 0x00 (wrap).
- Header 0x40 (64 words, counting pattern) → 64 writes at 0x00..0xFC, done=1, and the read port returns every word.
